// File: rtl/generador_trafico.sv
// Traffic generator: pushes channel/sequence-tagged words into a multi-channel
// DUT, then drains every channel and checks the read-back streams.
module generador_trafico #(
  parameter int DATA_WIDTH  = 12,
  parameter int CHANNELS    = 4,
  parameter int NUM_WORDS   = 64,
  parameter int INIT_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic [$clog2(CHANNELS)-1:0]    chan_sel,
  input  logic [CHANNELS-1:0]            dut_full,
  input  logic [CHANNELS-1:0]            dut_empty,
  input  logic [CHANNELS*DATA_WIDTH-1:0] dut_data,
  output logic                           init,
  output logic                           push,
  output logic [DATA_WIDTH-1:0]          data_in,
  output logic [CHANNELS-1:0]            pop,
  output logic                           done,
  output logic                           timeout,
  output logic [15:0]                    error_count,
  output logic [15:0]                    words_sent,
  output logic [15:0]                    words_checked
);

  localparam int CW = $clog2(CHANNELS);
  localparam int SW = DATA_WIDTH - CW;

  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

  state_t                state, next_state;
  logic [7:0]            lfsr;
  logic                  lfsr_fb;
  logic [CW-1:0]         rr;
  logic [CW-1:0]         target;
  logic [SW-1:0]         seq     [CHANNELS];
  logic [SW-1:0]         exp_seq [CHANNELS];
  logic [CHANNELS-1:0]   pop_q;
  logic [15:0]           init_cnt;
  logic [7:0]            drain_cnt;
  logic [2:0]            empty_run;
  logic                  start_run;
  logic                  drain_ok;
  logic                  drain_exit;
  logic                  drain_to;

  logic [CW-1:0]         rx_ch  [CHANNELS];
  logic [SW-1:0]         rx_seq [CHANNELS];
  logic [CHANNELS-1:0]   bad;
  logic [3:0]            n_chk;
  logic [3:0]            n_err;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    start_run  = start && (state == IDLE || state == DONE);
    drain_ok   = (&dut_empty) && (pop_q == '0);
    drain_exit = drain_ok && (empty_run == 3'd3);
    drain_to   = !drain_exit && (drain_cnt == 8'hFF);
    case (mode)
      2'd1:    target = chan_sel;
      2'd2:    target = lfsr[CW-1:0];
      default: target = rr;
    endcase
  end

  always_comb begin
    next_state = state;
    init       = 1'b0;
    push       = 1'b0;
    data_in    = '0;
    pop        = '0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = INIT;
      INIT: begin
        init = 1'b1;
        if (init_cnt == 16'(INIT_CYCLES - 1)) next_state = RUN;
      end
      RUN: begin
        data_in = {target, seq[target]};
        push    = !dut_full[target];
        pop     = ~dut_empty;
        if (push && words_sent == 16'(NUM_WORDS - 1)) next_state = DRAIN;
      end
      DRAIN: begin
        pop = ~dut_empty;
        if (drain_exit || drain_to) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) next_state = INIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read data for a pop issued last cycle is checked against the tag it must carry.
  always_comb begin
    bad   = '0;
    n_chk = '0;
    n_err = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rx_ch[i]  = dut_data[i*DATA_WIDTH + SW +: CW];
      rx_seq[i] = dut_data[i*DATA_WIDTH +: SW];
      bad[i]    = pop_q[i] && (rx_ch[i] != CW'(i) || rx_seq[i] != exp_seq[i]);
      if (pop_q[i]) n_chk = n_chk + 4'd1;
      if (bad[i])   n_err = n_err + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lfsr          <= 8'hA5;
      rr            <= '0;
      pop_q         <= '0;
      init_cnt      <= '0;
      drain_cnt     <= '0;
      empty_run     <= '0;
      timeout       <= 1'b0;
      error_count   <= '0;
      words_sent    <= '0;
      words_checked <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        seq[i]     <= '0;
        exp_seq[i] <= '0;
      end
    end else begin
      state <= next_state;
      pop_q <= pop;
      if (start_run) begin
        lfsr          <= 8'hA5;
        rr            <= '0;
        init_cnt      <= '0;
        drain_cnt     <= '0;
        empty_run     <= '0;
        timeout       <= 1'b0;
        error_count   <= '0;
        words_sent    <= '0;
        words_checked <= '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          seq[i]     <= '0;
          exp_seq[i] <= '0;
        end
      end else begin
        if (state == INIT) init_cnt <= init_cnt + 16'd1;
        if (push) begin
          seq[target] <= seq[target] + SW'(1);
          rr          <= rr + CW'(1);
          lfsr        <= {lfsr[6:0], lfsr_fb};
          words_sent  <= sat_add(words_sent, 4'd1);
        end
        // A mismatch resynchronises to the received sequence so one bad word counts once.
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (pop_q[i]) exp_seq[i] <= bad[i] ? rx_seq[i] + SW'(1) : exp_seq[i] + SW'(1);
        end
        words_checked <= sat_add(words_checked, n_chk);
        error_count   <= sat_add(error_count, n_err);
        if (state == DRAIN) begin
          drain_cnt <= drain_cnt + 8'd1;
          empty_run <= drain_ok ? empty_run + 3'd1 : 3'd0;
          if (drain_to) timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/generador_trafico.md
GENERADOR_TRAFICO -- requirements
Module: generador_trafico

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning word width on push and pop paths.
REQ-002 SHALL have parameter CHANNELS, default 4, meaning output channel count, a power of two from 2 to 8; CW = log2(CHANNELS).
REQ-003 SHALL have parameter NUM_WORDS, default 64, meaning words generated per run, from 1 to 65535.
REQ-004 SHALL have parameter INIT_CYCLES, default 2, meaning cycles `init` is held high.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: begin a run; sampled only in IDLE or DONE.
REQ-008 SHALL have port mode, input, 2: 0 round-robin, 1 fixed channel, 2 LFSR-random, 3 treated as 0.
REQ-009 SHALL have port chan_sel, input, CW: target channel when mode=1.
REQ-010 SHALL have port dut_full, input, CHANNELS: per-channel almost-full from the DUT.
REQ-011 SHALL have port dut_empty, input, CHANNELS: per-channel empty from the DUT.
REQ-012 SHALL have port dut_data, input, CHANNELS*DATA_WIDTH: channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port init, output, 1: DUT initialisation pulse.
REQ-014 SHALL have port push, output, 1: write strobe to the DUT.
REQ-015 SHALL have port data_in, output, DATA_WIDTH: word written to the DUT.
REQ-016 SHALL have port pop, output, CHANNELS: per-channel read strobes.
REQ-017 SHALL have ports done (1), timeout (1), error_count (16), words_sent (16), words_checked (16), all outputs.

Function
REQ-018 SHALL use a registered FSM with states IDLE, INIT, RUN, DRAIN and DONE.
REQ-019 SHALL move from IDLE or DONE to INIT on start=1, clearing the counters and timeout, and seeding the LFSR to 8'hA5.
REQ-020 SHALL assert init for exactly INIT_CYCLES cycles in INIT, then enter RUN.
REQ-021 SHALL format each word as data_in[DW-1:DW-CW] = destination channel and data_in[DW-CW-1:0] = that channel's sequence number, mod 2^(DW-CW), starting at 0.
REQ-022 SHALL select the RUN target as follows: mode 0 cycles 0..CHANNELS-1 and wraps; mode 1 uses chan_sel; mode 2 uses lfsr[CW-1:0] with LFSR polynomial x^8+x^6+x^5+x^4+1.
REQ-023 SHALL, in RUN, assert push with a valid data_in in a cycle only when dut_full[target]=0; otherwise push=0 and the target, LFSR and sequence numbers hold (stall).
REQ-024 SHALL advance the target, LFSR, that channel's sequence number and words_sent only on an accepted push.
REQ-025 SHALL enter DRAIN on the cycle after words_sent reaches NUM_WORDS; push is 0 in DRAIN.
REQ-026 SHALL, in RUN and DRAIN, drive pop[i] = !dut_empty[i] for each channel independently; pops are never issued in other states.
REQ-027 SHALL treat DUT read latency as 1 cycle: for pop[i] in cycle t, it compares the dut_data slice i in cycle t+1 against destination i and expected sequence exp_seq[i].
REQ-028 SHALL, for each checked word, increment words_checked and exp_seq[i]; on a channel-field or sequence mismatch it increments error_count and resynchronises exp_seq[i] to the received sequence + 1.
REQ-029 SHALL saturate error_count, words_sent and words_checked at 16'hFFFF.
REQ-030 SHALL leave DRAIN for DONE when dut_empty is all-ones for 4 consecutive cycles with no read in flight, or after 256 DRAIN cycles with timeout=1.
REQ-031 SHALL, in DONE, hold done=1 and keep all counters stable until the next start.
REQ-032 SHALL ignore start in INIT, RUN and DRAIN.

Reset
REQ-033 SHALL, on reset=1 and regardless of clk, force state IDLE; init, push, pop, done and timeout to 0; data_in, all counters, sequence numbers and exp_seq to 0; and the LFSR to 8'hA5.
REQ-034 SHALL abort a run on reset mid-RUN or mid-DRAIN, discard any in-flight comparison, and remain in IDLE after deassertion until start.

Verification
REQ-035 SHALL be verified for mode 0, NUM_WORDS=8, loopback DUT, no full -> data_in sequence 0x000, 0x400, 0x800, 0xC00, 0x001, 0x401, ...; then done=1, words_checked=8, error_count=0.
REQ-036 SHALL be verified for mode 1, chan_sel=2, dut_full[2] high for cycles 3-7 of RUN -> push=0 during the stall and data_in holds 0x802; no words are skipped.
REQ-037 SHALL be verified for a loopback that corrupts the sequence field of one channel-1 word -> error_count=1, and subsequent words check clean.
REQ-038 SHALL be verified with dut_empty forced to 0 after RUN -> timeout=1 and done=1 after 256 DRAIN cycles.
REQ-039 SHALL be verified with reset asserted mid-RUN at words_sent=5 -> all outputs 0 asynchronously; a new start restarts at sequence 0.
REQ-040 SHALL be verified for mode 2 -> target order follows the LFSR from 8'hA5, with identical order on two runs.
